// File: rtl/writeback_regfile.sv
// Writeback result select, 32-entry integer register file with write-through
// read bypass, and a free-running count of committed register writes.
module writeback_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     alu_result_w_i,
    input  logic [DATA_WIDTH-1:0]     read_data_w_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_w_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_w_i,
    input  logic [REGISTER_WIDTH-1:0] rd_w_i,
    input  logic [1:0]                result_src_w_i,
    input  logic                      reg_write_w_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
    output logic [DATA_WIDTH-1:0]     rd1_d_o,
    output logic [DATA_WIDTH-1:0]     rd2_d_o,
    output logic [DATA_WIDTH-1:0]     result_w_o,
    output logic [31:0]               wb_count_o
);

    localparam int NUM_REGS = 2 ** REGISTER_WIDTH;

    logic [DATA_WIDTH-1:0] result;
    logic                  commit;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [31:0]           count_reg;
    logic [31:0]           count_next;

    always_comb begin
        result = alu_result_w_i;
        case (result_src_w_i)
            2'b00:   result = alu_result_w_i;
            2'b01:   result = read_data_w_i;
            2'b10:   result = pc_plus4_w_i;
            default: result = imm_ext_w_i;
        endcase
    end

    assign commit = reg_write_w_i && (rd_w_i != '0);
    // Bypass is gated by reset so reads stay zero while rst_n is low.
    assign bypass = reg_write_w_i && rst_n;

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (commit && (rd_w_i == REGISTER_WIDTH'(gi))) begin
                    value_reg <= result;
                end
            end

            assign regs[gi] = value_reg;
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REGISTER_WIDTH-1:0] index);
        if (index == '0) begin
            return '0;
        end else if (bypass && (rd_w_i == index)) begin
            return result;
        end else begin
            return regs[index];
        end
    endfunction

    always_comb begin
        rd1_d_o = read_port(rs1_d_i);
        rd2_d_o = read_port(rs2_d_i);
    end

    assign count_next = count_reg + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (commit) begin
            count_reg <= count_next;
        end
    end

    assign result_w_o = result;
    assign wb_count_o = count_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: expected outputs are queued as each
// step is driven and popped for comparison once the outputs have settled.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result_w_i;
    logic [31:0] read_data_w_i;
    logic [31:0] pc_plus4_w_i;
    logic [31:0] imm_ext_w_i;
    logic [4:0]  rd_w_i;
    logic [1:0]  result_src_w_i;
    logic        reg_write_w_i;
    logic [4:0]  rs1_d_i;
    logic [4:0]  rs2_d_i;
    logic [31:0] rd1_d_o;
    logic [31:0] rd2_d_o;
    logic [31:0] result_w_o;
    logic [31:0] wb_count_o;

    writeback_regfile #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_result_w_i (alu_result_w_i),
        .read_data_w_i  (read_data_w_i),
        .pc_plus4_w_i   (pc_plus4_w_i),
        .imm_ext_w_i    (imm_ext_w_i),
        .rd_w_i         (rd_w_i),
        .result_src_w_i (result_src_w_i),
        .reg_write_w_i  (reg_write_w_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rd1_d_o        (rd1_d_o),
        .rd2_d_o        (rd2_d_o),
        .result_w_o     (result_w_o),
        .wb_count_o     (wb_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          which;   // 0 rd1, 1 rd2, 2 result, 3 count
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_regs [32];
    logic [31:0] model_count;
    int          checks;
    int          errors;

    function automatic logic [31:0] model_mux(input logic [1:0] src, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c,
                                              input logic [31:0] d);
        case (src)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [31:0] res);
        if (idx == 5'd0 || !rst_n) return 32'd0;
        if (reg_write_w_i && rd_w_i == idx) return res;
        return model_regs[idx];
    endfunction

    task automatic push_expected(input string tag);
        logic [31:0] res;
        res = model_mux(result_src_w_i, alu_result_w_i, read_data_w_i, pc_plus4_w_i, imm_ext_w_i);
        sb.push_back('{tag: {tag, ".rd1"},   which: 0, value: model_read(rs1_d_i, res)});
        sb.push_back('{tag: {tag, ".rd2"},   which: 1, value: model_read(rs2_d_i, res)});
        sb.push_back('{tag: {tag, ".res"},   which: 2, value: res});
        sb.push_back('{tag: {tag, ".count"}, which: 3, value: model_count});
    endtask

    task automatic drain_and_check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.which)
                0:       obs = rd1_d_o;
                1:       obs = rd2_d_o;
                2:       obs = result_w_o;
                default: obs = wb_count_o;
            endcase
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.value);
            end
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, then take the edge.
    task automatic step(input string tag, input logic we, input logic [4:0] rd,
                        input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] rdat, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2);
        logic [31:0] res;
        reg_write_w_i  = we;
        rd_w_i         = rd;
        result_src_w_i = src;
        alu_result_w_i = alu;
        read_data_w_i  = rdat;
        pc_plus4_w_i   = pc4;
        imm_ext_w_i    = imm;
        rs1_d_i        = r1;
        rs2_d_i        = r2;
        #1;
        push_expected(tag);
        drain_and_check();
        $display("step %-10s we=%0b rd=%0d src=%0d rs1=%0d rs2=%0d rd1=%h rd2=%h res=%h cnt=%h",
                 tag, we, rd, src, r1, r2, rd1_d_o, rd2_d_o, result_w_o, wb_count_o);
        res = model_mux(src, alu, rdat, pc4, imm);
        @(posedge clk);
        if (rst_n && we && rd != 5'd0) begin
            model_regs[rd] = res;
            model_count    = model_count + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic read_only(input string tag, input logic [4:0] r1, input logic [4:0] r2);
        step(tag, 1'b0, 5'd0, 2'd0, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0, r1, r2);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        rst_n = 1'b0;
        reg_write_w_i = 1'b0; rd_w_i = '0; result_src_w_i = '0;
        alu_result_w_i = '0; read_data_w_i = '0; pc_plus4_w_i = '0; imm_ext_w_i = '0;
        rs1_d_i = '0; rs2_d_i = '0;
        @(negedge clk);

        // Writes and bypass suppressed while held in reset.
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1'b1, 5'd5, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
        rst_n = 1'b1;

        step("x0_write", 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        read_only("x0_read", 5'd0, 5'd5);

        // Result mux, one source per register.
        for (int i = 0; i < 4; i++)
            step("mux_wr", 1'b1, 5'(i + 1), 2'(i), 32'h11, 32'h22, 32'h33, 32'h44, 5'(i + 1), 5'd0);
        read_only("mux_rd12", 5'd1, 5'd2);
        read_only("mux_rd34", 5'd3, 5'd4);

        // Same-cycle bypass on both ports.
        step("byp_pre", 1'b1, 5'd7, 2'd0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
        step("bypass", 1'b1, 5'd7, 2'd0, 32'h200, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
        read_only("byp_after", 5'd7, 5'd7);

        // Disabled write: no store, no bypass, mux still visible.
        step("x9_pre", 1'b1, 5'd9, 2'd1, 32'h0, 32'h55, 32'h0, 32'h0, 5'd0, 5'd0);
        step("wr_dis", 1'b0, 5'd9, 2'd0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9);
        read_only("dis_after", 5'd9, 5'd7);

        // Ten more commits, then asynchronous reset between edges.
        for (int i = 0; i < 10; i++)
            step("fill", 1'b1, 5'(10 + i), 2'(i % 4), $urandom, $urandom, $urandom, $urandom,
                 5'(10 + i), 5'($urandom_range(0, 31)));
        read_only("fill_rd", 5'd12, 5'd19);
        reg_write_w_i = 1'b1; rd_w_i = 5'd10; result_src_w_i = 2'd0;
        alu_result_w_i = 32'hCAFE_0001; rs1_d_i = 5'd10; rs2_d_i = 5'd11;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        push_expected("async_rst");
        drain_and_check();
        $display("step async_rst rd1=%h rd2=%h res=%h cnt=%h", rd1_d_o, rd2_d_o, result_w_o, wb_count_o);
        @(negedge clk);
        rst_n = 1'b1;
        read_only("post_rst", 5'd10, 5'd7);

        // Counter wrap from all-ones.
        force dut.count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.count_reg;
        model_count = 32'hFFFF_FFFF;
        step("wrap_pre", 1'b1, 5'd3, 2'd3, 32'h0, 32'h0, 32'h0, 32'h77, 5'd3, 5'd0);
        step("wrap_post", 1'b1, 5'd4, 2'd2, 32'h0, 32'h0, 32'h88, 32'h0, 5'd3, 5'd4);
        read_only("wrap_rd", 5'd3, 5'd4);

        // A few random transactions against the model.
        for (int i = 0; i < 20; i++)
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
